sequence_generator: RTL and testbench

Pattern generator that sits upstream of the game controller in the memory game. On a start request (`GoGen`) it writes a pseudo-random digit sequence into the sequence RAM. Sequence length is set by the controller's difficulty level. When the fill is complete it raises `FinGen`. The controller then replays the RAM contents through `SeqAddr`/`RAMOutput`.

---
 rtl/sequence_generator.sv | 128 ++++++++++++
 tb/tb_sequence_generator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Fills the sequence RAM with LFSR digits 0..9 on a GoGen rise; first write the cycle after the start edge, no backpressure.
// SEQGEN_NO_REPEAT_EN: also reject a candidate equal to the previous digit written in the current fill.
module sequence_generator #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned BASE_LEN  = 4,
  parameter int unsigned LEN_STEP  = 2,
  parameter int unsigned MAX_LEN   = 32
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       GoGen,
  input  logic [3:0] Diff,
  output logic       WrEn,
  output logic [4:0] WrAddr,
  output logic [3:0] WrData,
  output logic [5:0] SeqLen,
  output logic       Busy,
  output logic       FinGen
);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        gogen_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  len_calc;
  logic [3:0]  cand;
  logic        cand_ok;
  logic        start;
  int unsigned raw_len;

`ifdef SEQGEN_NO_REPEAT_EN
  logic [3:0]  prev_q, prev_d;
  logic        prev_vld_q, prev_vld_d;
`endif

  assign start  = GoGen & ~gogen_q;
  assign cand   = lfsr_q[3:0];
  assign SeqLen = len_q;

  // Galois step, polynomial x^16+x^14+x^13+x^11+1; runs in every state.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    raw_len  = BASE_LEN + LEN_STEP * 32'(Diff);
    len_calc = (raw_len > MAX_LEN) ? 6'(MAX_LEN) : 6'(raw_len);
  end

`ifdef SEQGEN_NO_REPEAT_EN
  assign cand_ok = (cand <= 4'd9) && !(prev_vld_q && (cand == prev_q));
`else
  assign cand_ok = (cand <= 4'd9);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    WrEn    = 1'b0;
    WrAddr  = 5'd0;
    WrData  = 4'd0;
    Busy    = 1'b0;
    FinGen  = 1'b0;
`ifdef SEQGEN_NO_REPEAT_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        FinGen = (state_q == DONE);
        if (start) begin
          len_d   = len_calc;
          cnt_d   = 5'd0;
          state_d = GEN;
`ifdef SEQGEN_NO_REPEAT_EN
          prev_vld_d = 1'b0;
`endif
        end
      end
      GEN: begin
        Busy = 1'b1;
        if (cand_ok) begin
          WrEn   = 1'b1;
          WrAddr = cnt_q;
          WrData = cand;
          cnt_d  = cnt_q + 5'd1;
`ifdef SEQGEN_NO_REPEAT_EN
          prev_d     = cand;
          prev_vld_d = 1'b1;
`endif
          if ({1'b0, cnt_q} == len_q - 6'd1) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      gogen_q <= 1'b0;
      cnt_q   <= 5'd0;
      len_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      gogen_q <= GoGen;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

`ifdef SEQGEN_NO_REPEAT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      prev_q     <= 4'd0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with an independent LFSR reference model.
module tb_sequence_generator;

  logic       Clk, Rst, GoGen;
  logic [3:0] Diff;
  logic       WrEn, Busy, FinGen;
  logic [4:0] WrAddr;
  logic [3:0] WrData;
  logic [5:0] SeqLen;

  int checks = 0;
  int passed = 0;

  sequence_generator dut (
    .Clk(Clk), .Rst(Rst), .GoGen(GoGen), .Diff(Diff),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .SeqLen(SeqLen), .Busy(Busy), .FinGen(FinGen)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference LFSR: right-shift Galois with feedback mask 0xB400.
  logic [15:0] m;
  function automatic logic [15:0] step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) m <= 16'hACE1;
    else      m <= step(m);
  end

  // Called at a negedge with GoGen low; returns at a negedge.
  task automatic run_fill(input logic [3:0] diff, input int exp_len,
                          input int pulse_cyc, input int abort_after, output int nwr);
    int cnt, cyc, dut_wr;
    bit done, ok, pv;
    logic [3:0] cand, prev;
    cnt = 0; cyc = 0; dut_wr = 0; done = 0; pv = 0; prev = 4'd0;
    Diff = diff; GoGen = 1'b1;
    @(negedge Clk);
    GoGen = 1'b0;
    Diff = ~diff;
    checks++;
    if (SeqLen !== 6'(exp_len)) $display("FAIL seqlen diff=%0d got %0d want %0d", diff, SeqLen, exp_len);
    else passed++;
    while (!done && cyc < 2000) begin
      cand = m[3:0];
      ok = (cand <= 4'd9);
`ifdef SEQGEN_NO_REPEAT_EN
      if (pv && cand == prev) ok = 1'b0;
`endif
      checks++;
      if ({Busy, FinGen} !== 2'b10) $display("FAIL busy_fin cyc=%0d got %b want 10", cyc, {Busy, FinGen});
      else passed++;
      checks++;
      if (WrEn !== ok) $display("FAIL wren cyc=%0d got %b want %b", cyc, WrEn, ok);
      else passed++;
      checks++;
      if (ok) begin
        if ({WrAddr, WrData} !== {5'(cnt), cand})
          $display("FAIL wr_addr_data got %0d/%0d want %0d/%0d", WrAddr, WrData, cnt, cand);
        else passed++;
      end else begin
        if ({WrAddr, WrData} !== 9'd0) $display("FAIL idle_addr_data got %0d/%0d want 0/0", WrAddr, WrData);
        else passed++;
      end
      if (WrEn === 1'b1) dut_wr++;
      if (ok) begin
        prev = cand; pv = 1'b1;
        if (cnt == exp_len - 1) done = 1'b1;
        cnt++;
      end
      if (abort_after > 0 && ok && cnt == abort_after) break;
      if (!done) begin
        GoGen = (cyc == pulse_cyc);
        @(negedge Clk);
        cyc++;
      end
    end
    GoGen = 1'b0;
    nwr = dut_wr;
    if (abort_after == 0) begin
      checks++;
      if (!done) $display("FAIL fill_timeout diff=%0d writes=%0d want %0d", diff, cnt, exp_len);
      else passed++;
      @(negedge Clk);
      checks++;
      if ({FinGen, Busy, WrEn} !== 3'b100) $display("FAIL fin_rise got fin/busy/wren=%b want 100", {FinGen, Busy, WrEn});
      else passed++;
      checks++;
      if (dut_wr != exp_len) $display("FAIL write_count got %0d want %0d", dut_wr, exp_len);
      else passed++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({WrEn, WrAddr, WrData} !== 10'd0) $display("FAIL reset_wr got %b want 0", {WrEn, WrAddr, WrData});
    else passed++;
    checks++;
    if (SeqLen !== 6'd0) $display("FAIL reset_seqlen got %0d want 0", SeqLen);
    else passed++;
    checks++;
    if ({Busy, FinGen} !== 2'b00) $display("FAIL reset_busy_fin got %b want 00", {Busy, FinGen});
    else passed++;
  endtask

  task automatic test_diff0();
    int n;
    run_fill(4'd0, 4, -1, 0, n);
    repeat (5) begin
      @(negedge Clk);
      checks++;
      if ({FinGen, Busy, WrEn} !== 3'b100) $display("FAIL fin_hold got %b want 100", {FinGen, Busy, WrEn});
      else passed++;
    end
  endtask

  task automatic test_lengths();
    int n;
    run_fill(4'd15, 32, -1, 0, n);
    run_fill(4'd5, 14, -1, 0, n);
    run_fill(4'd14, 32, -1, 0, n);
  endtask

  task automatic test_pulse_in_gen();
    int n;
    @(negedge Clk);
    run_fill(4'd5, 14, 2, 0, n);
    repeat (3) begin
      @(negedge Clk);
      checks++;
      if ({FinGen, Busy} !== 2'b10) $display("FAIL ignored_start got %b want 10", {FinGen, Busy});
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    // Starts straight from DONE; the first in-fill check sees FinGen already low.
    run_fill(4'd1, 6, -1, 0, n);
    run_fill(4'd2, 8, -1, 0, n);
  endtask

  task automatic test_reset_abort();
    int n;
    run_fill(4'd3, 10, -1, 3, n);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    checks++;
    if ({WrEn, WrAddr, WrData, SeqLen, Busy, FinGen} !== 18'd0)
      $display("FAIL abort_outputs got %b want 0", {WrEn, WrAddr, WrData, SeqLen, Busy, FinGen});
    else passed++;
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      checks++;
      if ({FinGen, Busy} !== 2'b00) $display("FAIL abort_fin got %b want 00", {FinGen, Busy});
      else passed++;
    end
    run_fill(4'd0, 4, -1, 0, n);
  endtask

  task automatic test_many_fills();
    int n;
`ifdef SEQGEN_NO_REPEAT_EN
    for (int i = 0; i < 200; i++) run_fill(4'd15, 32, -1, 0, n);
`else
    for (int i = 0; i < 4; i++) run_fill(4'd15, 32, -1, 0, n);
`endif
  endtask

  initial begin
    Rst = 1'b0; GoGen = 1'b0; Diff = 4'd0;
    repeat (2) @(negedge Clk);
    test_reset();
    Rst = 1'b1;
    @(negedge Clk);
    test_diff0();
    test_lengths();
    test_pulse_in_gen();
    test_back_to_back();
    test_reset_abort();
    test_many_fills();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
